csa_accum_pipe: RTL and testbench

- Pipelined multi-beat dot-product accumulator for the CNN datapath.
- Each accepted beat carries N W-bit operands. A carry-save tree reduces them to a sum/carry pair. A 4:2 compressor then folds that pair into a carry-save accumulator.
- On the frame's last beat, one carry-propagate add resolves the total.
- Successor to the single-shot combinational CSA: adds beat accumulation, valid/ready handshakes, overflow flagging and signed mode.

---
 rtl/csa_pkg.sv | 31 +++
 rtl/csa_tree_comb.sv | 66 ++++++
 rtl/csa_accum_pipe.sv | 136 +++++++++++++
 tb/tb_csa_accum_pipe.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// Shared types and helpers for the carry-save dot-product accumulator.
package csa_pkg;

  localparam int CSA_WORD_W = 64;
  typedef logic [CSA_WORD_W-1:0] csa_word_t;

  typedef enum logic [1:0] {ACCUM, DRAIN, RESOLVE, HOLD} state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int acc_width(input int w, input int e, input int be);
    return w + e + be;
  endfunction

  // 3:2 compressor on a wide word; callers truncate to their own width.
  function automatic csa_word_t csa32_sum(input csa_word_t a, input csa_word_t b,
                                          input csa_word_t c);
    return a ^ b ^ c;
  endfunction

  function automatic csa_word_t csa32_carry(input csa_word_t a, input csa_word_t b,
                                            input csa_word_t c);
    return ((a & b) | (a & c) | (b & c)) << 1;
  endfunction

endpackage

// File: rtl/csa_tree_comb.sv
// Combinational Wallace reduction of N operands to a sum/carry pair.
// CSA_ACCUM_SIGNED_EN selects sign extension of operands (default: zero extension).
module csa_tree_comb
  import csa_pkg::*;
#(
  parameter int N     = 9,
  parameter int W     = 4,
  parameter int ACC_W = 12
) (
  input  logic [W*N-1:0]   operands,
  output logic [ACC_W-1:0] sum,
  output logic [ACC_W-1:0] carry
);

  // Each Wallace level shrinks rows by ~2/3, so 2*clog2(N) levels always suffice.
  localparam int LEVELS = 2 * clog2(N);

  logic [ACC_W-1:0] ext [N];
  logic [ACC_W-1:0] rows [N];
  logic [ACC_W-1:0] rows_next [N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_ext
`ifdef CSA_ACCUM_SIGNED_EN
      assign ext[gi] = {{(ACC_W-W){operands[gi*W+W-1]}}, operands[gi*W +: W]};
`else
      assign ext[gi] = {{(ACC_W-W){1'b0}}, operands[gi*W +: W]};
`endif
    end
  endgenerate

  always_comb begin
    int cnt;
    int groups;
    int rem;
    rows      = ext;
    rows_next = '{default: '0};
    cnt       = N;
    for (int lvl = 0; lvl < LEVELS; lvl++) begin
      if (cnt > 2) begin
        groups    = cnt / 3;
        rem       = cnt % 3;
        rows_next = '{default: '0};
        for (int g = 0; g < N / 3; g++) begin
          if (g < groups) begin
            rows_next[2*g]   = ACC_W'(csa32_sum(csa_word_t'(rows[3*g]),
                                                csa_word_t'(rows[3*g+1]),
                                                csa_word_t'(rows[3*g+2])));
            rows_next[2*g+1] = ACC_W'(csa32_carry(csa_word_t'(rows[3*g]),
                                                  csa_word_t'(rows[3*g+1]),
                                                  csa_word_t'(rows[3*g+2])));
          end
        end
        // Leftover rows that did not fill a triple pass straight through.
        for (int r = 0; r < 2; r++) begin
          if (r < rem) rows_next[2*groups+r] = rows[3*groups+r];
        end
        rows = rows_next;
        cnt  = 2 * groups + rem;
      end
    end
    sum   = rows[0];
    carry = rows[1];
  end

endmodule

// File: rtl/csa_accum_pipe.sv
// Pipelined multi-beat carry-save dot-product accumulator with valid/ready handshakes.
// Define CSA_ACCUM_SIGNED_EN for two's-complement operands.
module csa_accum_pipe
  import csa_pkg::*;
#(
  parameter int N  = 9,
  parameter int W  = 4,
  parameter int E  = 4,
  parameter int BE = 4,
  localparam int ACC_W = acc_width(W, E, BE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [W*N-1:0]    in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic [BE:0]       out_beats,
  output logic              out_ovf,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam logic [BE:0] MAX_BEATS = {1'b1, {BE{1'b0}}};

  logic             accept;
  logic [ACC_W-1:0] tree_sum;
  logic [ACC_W-1:0] tree_carry;

  logic [ACC_W-1:0] s1_sum_reg;
  logic [ACC_W-1:0] s1_carry_reg;
  logic             s1_valid_reg;
  logic             s1_last_reg;
  logic             s1_first_reg;
  logic             first_pending_reg;

  logic [ACC_W-1:0] acc_s_reg;
  logic [ACC_W-1:0] acc_c_reg;
  logic [BE:0]      beat_cnt_reg;
  state_t           state_reg;

  logic [ACC_W-1:0] acc_s_next;
  logic [ACC_W-1:0] acc_c_next;

  assign accept = in_valid && in_ready;

  csa_tree_comb #(.N(N), .W(W), .ACC_W(ACC_W)) u_tree (
    .operands (in_data),
    .sum      (tree_sum),
    .carry    (tree_carry)
  );

  // 4:2 compressor folding the new beat into the carry-save accumulator.
  always_comb begin
    logic [ACC_W-1:0] op_s;
    logic [ACC_W-1:0] op_c;
    logic [ACC_W-1:0] l1_s;
    logic [ACC_W-1:0] l1_c;
    op_s = s1_first_reg ? '0 : acc_s_reg;
    op_c = s1_first_reg ? '0 : acc_c_reg;
    l1_s = ACC_W'(csa32_sum(csa_word_t'(op_s), csa_word_t'(op_c), csa_word_t'(s1_sum_reg)));
    l1_c = ACC_W'(csa32_carry(csa_word_t'(op_s), csa_word_t'(op_c), csa_word_t'(s1_sum_reg)));
    acc_s_next = ACC_W'(csa32_sum(csa_word_t'(l1_s), csa_word_t'(l1_c),
                                  csa_word_t'(s1_carry_reg)));
    acc_c_next = ACC_W'(csa32_carry(csa_word_t'(l1_s), csa_word_t'(l1_c),
                                    csa_word_t'(s1_carry_reg)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_sum_reg        <= '0;
      s1_carry_reg      <= '0;
      s1_valid_reg      <= 1'b0;
      s1_last_reg       <= 1'b0;
      s1_first_reg      <= 1'b0;
      first_pending_reg <= 1'b1;
      acc_s_reg         <= '0;
      acc_c_reg         <= '0;
      beat_cnt_reg      <= '0;
      state_reg         <= ACCUM;
      in_ready          <= 1'b1;
      out_data          <= '0;
      out_beats         <= '0;
      out_ovf           <= 1'b0;
      out_valid         <= 1'b0;
    end else begin
      s1_valid_reg <= accept;
      if (accept) begin
        s1_sum_reg        <= tree_sum;
        s1_carry_reg      <= tree_carry;
        s1_last_reg       <= in_last;
        s1_first_reg      <= first_pending_reg;
        first_pending_reg <= in_last;
      end

      if (s1_valid_reg) begin
        acc_s_reg <= acc_s_next;
        acc_c_reg <= acc_c_next;
        if (s1_first_reg)
          beat_cnt_reg <= (BE+1)'(1);
        else if (!(&beat_cnt_reg))
          beat_cnt_reg <= beat_cnt_reg + 1'b1;
      end

      case (state_reg)
        ACCUM: begin
          if (accept && in_last) begin
            state_reg <= DRAIN;
            in_ready  <= 1'b0;
          end
        end
        DRAIN: begin
          if (s1_valid_reg && s1_last_reg) state_reg <= RESOLVE;
        end
        RESOLVE: begin
          out_data  <= acc_s_reg + acc_c_reg;
          out_beats <= beat_cnt_reg;
          out_ovf   <= (beat_cnt_reg > MAX_BEATS);
          out_valid <= 1'b1;
          state_reg <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid    <= 1'b0;
            beat_cnt_reg <= '0;
            in_ready     <= 1'b1;
            state_reg    <= ACCUM;
          end
        end
        default: state_reg <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_accum_pipe.sv
// Self-checking bench for csa_accum_pipe: frame vector table, scoreboard, corner sequences.
module tb_csa_accum_pipe;

  localparam int N     = 9;
  localparam int W     = 4;
  localparam int BE    = 4;
  localparam int ACC_W = 12;

  logic              clk;
  logic              rst_n;
  logic [W*N-1:0]    in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [ACC_W-1:0]  out_data;
  logic [BE:0]       out_beats;
  logic              out_ovf;
  logic              out_valid;
  logic              out_ready;

  csa_accum_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_beats (out_beats),
    .out_ovf   (out_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [ACC_W-1:0] d;
    logic [BE:0]      b;
    logic             o;
  } exp_t;

  typedef struct {
    int               nb;
    int               mode;
    int               hold;
    logic [ACC_W-1:0] d;
    logic [BE:0]      b;
    logic             o;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];
  int   tests = 0;
  int   fails = 0;
  bit   chk_ready_next = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic note_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got timeout/none, expected event", name);
  endtask

  function automatic logic [W*N-1:0] make_beat(input int mode);
    logic [W*N-1:0] d;
    d = '0;
    for (int k = 0; k < N; k++) begin
      case (mode)
        0:       d[k*W +: W] = 4'hF;
        1:       d[k*W +: W] = W'(k);
        2:       d[k*W +: W] = 4'h1;
        3:       d[k*W +: W] = 4'h0;
        default: d[k*W +: W] = W'($urandom_range(0, 15));
      endcase
    end
    return d;
  endfunction

  // Reference: plain integer sum of operand values, wrapped to ACC_W bits.
  function automatic logic [ACC_W-1:0] model_add(input logic [ACC_W-1:0] acc,
                                                 input logic [W*N-1:0] d);
    int v;
    for (int k = 0; k < N; k++) begin
      v = int'(d[k*W +: W]);
`ifdef CSA_ACCUM_SIGNED_EN
      if (v >= 8) v = v - 16;
`endif
      acc = acc + ACC_W'(v);
    end
    return acc;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (chk_ready_next) begin
      check("in_ready_after_handshake", in_ready, 1);
      chk_ready_next = 1'b0;
    end
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        note_fail("unexpected_output");
      end else begin
        e = sb.pop_front();
        check("out_data", out_data, e.d);
        check("out_beats", out_beats, e.b);
        check("out_ovf", out_ovf, e.o);
        $display("[TB] frame out data=%0h beats=%0d ovf=%0b", out_data, out_beats, out_ovf);
      end
      check("no_bypass_in_ready", in_ready, 0);
      chk_ready_next = 1'b1;
    end
  end

  task automatic drive_beat(input logic [W*N-1:0] d, input logic last, output logic ok);
    in_data  = d;
    in_valid = 1'b1;
    in_last  = last;
    ok       = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) note_fail("accept_timeout");
    else @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_frame(input int nb, input int mode, input int hold, input logic use_model,
                           input logic [ACC_W-1:0] exp_d, input logic [BE:0] exp_b,
                           input logic exp_o);
    logic [ACC_W-1:0] acc;
    logic [W*N-1:0]   d;
    logic             ok;
    logic             seen;
    int               lat;
    exp_t             e;
    logic [ACC_W-1:0] snap_d;
    logic [BE:0]      snap_b;
    logic             snap_o;
    acc       = '0;
    out_ready = (hold == 0);
    for (int b = 0; b < nb; b++) begin
      d   = make_beat(mode);
      acc = model_add(acc, d);
      drive_beat(d, (b == nb - 1), ok);
      if (!ok) return;
    end
    e.d = use_model ? acc : exp_d;
    e.b = exp_b;
    e.o = exp_o;
    sb.push_back(e);
    lat  = 0;
    seen = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      lat++;
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      check("in_ready_low_while_busy", in_ready, 0);
    end
    if (!seen) begin
      note_fail("out_valid_timeout");
      out_ready = 1'b1;
      return;
    end
    check("latency", lat, 3);
    if (hold > 0) begin
      snap_d   = out_data;
      snap_b   = out_beats;
      snap_o   = out_ovf;
      in_valid = 1'b1;
      in_last  = 1'b1;
      in_data  = make_beat(4);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check("hold_stable", {out_valid, out_ovf, out_beats, out_data},
              {1'b1, snap_o, snap_b, snap_d});
        check("hold_in_ready", in_ready, 0);
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic ok;
    int   nb;
    logic [BE:0] eb;

`ifdef CSA_ACCUM_SIGNED_EN
    vecs[0] = '{1,  0, 0,  12'hFF7,  5'd1,  1'b0};
    vecs[1] = '{3,  1, 0,  12'h03C,  5'd3,  1'b0};
    vecs[2] = '{1,  1, 10, 12'h014,  5'd1,  1'b0};
    vecs[3] = '{17, 0, 0,  12'hF67,  5'd17, 1'b1};
    vecs[5] = '{16, 0, 0,  12'hF70,  5'd16, 1'b0};
    vecs[6] = '{32, 0, 2,  12'hEE0,  5'd31, 1'b1};
`else
    vecs[0] = '{1,  0, 0,  12'h087,  5'd1,  1'b0};
    vecs[1] = '{3,  1, 0,  12'h06C,  5'd3,  1'b0};
    vecs[2] = '{1,  1, 10, 12'h024,  5'd1,  1'b0};
    vecs[3] = '{17, 0, 0,  12'h8F7,  5'd17, 1'b1};
    vecs[5] = '{16, 0, 0,  12'h870,  5'd16, 1'b0};
    vecs[6] = '{32, 0, 2,  12'h0E0,  5'd31, 1'b1};
`endif
    vecs[4] = '{1,  3, 0,  12'h000,  5'd1,  1'b0};
    vecs[7] = '{2,  2, 0,  12'h012,  5'd2,  1'b0};

    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #23;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_out_beats", out_beats, 0);
    check("reset_out_ovf", out_ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      $display("[TB] vector %0d: beats=%0d mode=%0d hold=%0d", i, vecs[i].nb, vecs[i].mode,
               vecs[i].hold);
      run_frame(vecs[i].nb, vecs[i].mode, vecs[i].hold, 1'b0, vecs[i].d, vecs[i].b, vecs[i].o);
    end

    // Reset in the middle of a 4-beat frame, then a clean single-beat frame.
    $display("[TB] mid-frame reset sequence");
    out_ready = 1'b1;
    drive_beat(make_beat(2), 1'b0, ok);
    drive_beat(make_beat(2), 1'b0, ok);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_in_ready", in_ready, 1);
    check("midreset_out_valid", out_valid, 0);
    check("midreset_out_data", out_data, 0);
    check("midreset_out_beats", out_beats, 0);
    check("midreset_out_ovf", out_ovf, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_frame(1, 2, 0, 1'b0, 12'h009, 5'd1, 1'b0);

    for (int i = 0; i < 60; i++) begin
      nb = $urandom_range(1, 34);
      eb = (nb > 31) ? 5'd31 : 5'(nb);
      $display("[TB] random frame %0d: beats=%0d", i, nb);
      run_frame(nb, 4, $urandom_range(0, 3), 1'b1, '0, eb, (nb > 16));
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
